seg7_bcd_scanner: RTL and testbench
===================================

Name: seg7_bcd_scanner

Overview:
Reads the four BCD digits produced by the cascaded mod-10 score/timer counters and time-multiplexes them onto a 4-digit common-anode 7-segment display. A refresh divider steps the active digit. The block snapshots the digit bus once per scan frame so all four digits shown in a frame come from the same instant. It also provides leading-zero blanking, per-digit decimal points, per-digit blinking, and a dash glyph for non-BCD codes.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays active (1 kHz digit rate at 100 MHz); legal range >= 2
BLINK_FRAMES, 125, full scan frames per blink half-period (about 0.5 s at defaults); legal range >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-high reset
digits  input  16  BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3 (leftmost)
blank_lz  input  1  1 = blank leading zeros in digits 3..1
dp_mask  input  4  1 = light decimal point of digit i
blink_en  input  4  1 = digit i blinks
seg  output  7  {g,f,e,d,c,b,a}, active low, registered
dp  output  1  decimal point, active low, registered
an  output  4  digit anodes, active low, one-hot-low, registered

Behaviour:
- Reset: clk and clr are already decided. The reset is synchronous, active-high, named clr. While clr=1 at a rising edge:
  - refresh counter, digit index, frame counter and blink phase go to 0
  - the snapshot register loads 0
  - an=4'b1111, seg=7'b1111111, dp=1
- Reset mid-scan: clr blanks all outputs on the next edge, regardless of counter state.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps to 0. Its wrap cycle is "step".
- Digit index: 2-bit, 0->1->2->3->0, advances on step.
- Snapshot: on the step where index goes 3->0, and on the first cycle after clr deasserts, load digits, dp_mask, blink_en and blank_lz into the snapshot register. Mid-frame input changes never affect the current frame.
- Frame counter: counts frames 0..BLINK_FRAMES-1. At its wrap (coincident with the 3->0 step), blink_phase toggles.
- Output timing: an/seg/dp are registered from the current index and snapshot, so they lag index by 1 cycle.
  - First cycle after clr deasserts: outputs still blank.
  - Cycle 2 onward: digit0 is driven (an=4'b1110).
- Anode: an[i]=0 only for i==index, except that an=4'b1111 when the digit is blanked. Exactly one anode is low at any time unless the digit is blanked.
- Decode: 0..9 use standard glyphs. Examples: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, 9=7'b0010000. Codes 10..15 show dash 7'b0111111.
- Leading-zero blanking (when snapshot blank_lz=1):
  - digit i (i=3..1) is blanked if it and every higher digit equal 0
  - digit0 is never zero-blanked
  - a non-BCD code counts as nonzero
- Blink: when blink_phase=1 and snapshot blink_en[i]=1, digit i is blanked.
- Blanked digit: an all high, seg=7'b1111111, dp=1. Blanking overrides dp_mask.
- dp: dp = ~dp_mask[index] unless the digit is blanked.
- Simultaneous events: clr dominates everything. The snapshot load and blink toggle on the same edge both take effect. The new blink phase applies from digit0 of the new frame.

Decomposition:
- Shared package seg7_pkg holds:
  - segment glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - NUM_DIGITS=4
  - the anode-off constant AN_OFF=4'b1111
- One combinational sub-module, bcd_to_seg7 (4-bit BCD in, 7-bit active-low segments out, dash for 10..15). It is reused by other display logic in the design.
- Divider, index, frame/blink counters and output registers live in seg7_bcd_scanner.

Test Plan:
- Reset/first frame (REFRESH_DIV=4, BLINK_FRAMES=2): clr=1 for 3 cycles, digits=16'h1234, all controls 0, then release.
  - Required: an=1111 and seg=1111111 on the first cycle after release.
  - Then an cycles 1110,1101,1011,0111, each held 4 cycles.
  - seg shows 4,3,2,1 in that order.
- Leading zeros: digits=16'h0050, blank_lz=1.
  - Required: digits 3 and 2 blanked (an=1111 in their slots); digit1 shows 5, digit0 shows 0.
  - With digits=16'h0000: only digit0 is lit, showing 0.
- Snapshot coherence: change digits from 16'h1111 to 16'h9999 while index=1.
  - Required: the rest of that frame still shows 1.
  - 9 appears from digit0 of the next frame.
- Blink (BLINK_FRAMES=2): blink_en=4'b0001.
  - Required: digit0 lit for 2 frames, blanked for 2 frames, repeating.
  - Other digits are unaffected.
- DP and invalid code: digits=16'hA000, dp_mask=4'b1000, blank_lz=1.
  - Required: digit3 shows dash 0111111 with dp=0.
  - Digits 2..0 are not zero-blanked, because the nonzero code sits above them.
- Mid-scan reset: assert clr while index=2.
  - Required: all outputs blank on the next edge.
  - After release, the scan restarts at digit0 with a fresh snapshot.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyphs and display constants
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Glyphs are {g,f,e,d,c,b,a}, active low
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low 7-segment glyph, dash for 10..15
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_scanner.sv
// rtl/seg7_bcd_scanner.sv - 4-digit multiplexed 7-segment scanner with frame snapshot,
// leading-zero blanking, decimal points and per-digit blink
module seg7_bcd_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);

  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic          first_q, first_d;
  logic [15:0]   snap_dig_q, snap_dig_d;
  logic          snap_lz_q, snap_lz_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0] snap_bl_q, snap_bl_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          step, frame_end, load_snap, lz_blank, blank;
  logic [3:0]    cur_digit;
  logic [6:0]    glyph;

  assign cur_digit = snap_dig_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (glyph)
  );

  always_comb begin
    step      = (refresh_q == REF_MAX);
    frame_end = step && (idx_q == 2'd3);
    // The cycle right after reset only captures the snapshot; scanning starts after it
    load_snap = first_q || frame_end;

    refresh_d = refresh_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    blink_d   = blink_q;
    first_d   = 1'b0;
    if (!first_q) begin
      refresh_d = step ? '0 : refresh_q + RW'(1);
      if (step) idx_d = idx_q + 2'd1;
      if (frame_end) begin
        frame_d = (frame_q == FR_MAX) ? '0 : frame_q + FW'(1);
        if (frame_q == FR_MAX) blink_d = ~blink_q;
      end
    end

    snap_dig_d = load_snap ? digits   : snap_dig_q;
    snap_lz_d  = load_snap ? blank_lz : snap_lz_q;
    snap_dp_d  = load_snap ? dp_mask  : snap_dp_q;
    snap_bl_d  = load_snap ? blink_en : snap_bl_q;

    // A digit is a leading zero when it and everything to its left is zero
    lz_blank = 1'b0;
    case (idx_q)
      2'd3: lz_blank = (snap_dig_q[15:12] == 4'd0);
      2'd2: lz_blank = (snap_dig_q[15:8]  == 8'd0);
      2'd1: lz_blank = (snap_dig_q[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
    blank = first_q || (snap_lz_q && lz_blank) || (blink_q && snap_bl_q[idx_q]);

    an_d  = blank ? AN_OFF  : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_OFF : glyph;
    dp_d  = blank ? 1'b1    : ~snap_dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      refresh_q  <= '0;
      idx_q      <= 2'd0;
      frame_q    <= '0;
      blink_q    <= 1'b0;
      first_q    <= 1'b1;
      snap_dig_q <= 16'd0;
      snap_lz_q  <= 1'b0;
      snap_dp_q  <= '0;
      snap_bl_q  <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      first_q    <= first_d;
      snap_dig_q <= snap_dig_d;
      snap_lz_q  <= snap_lz_d;
      snap_dp_q  <= snap_dp_d;
      snap_bl_q  <= snap_bl_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// tb/tb_seg7_bcd_scanner.sv - randomized self-checking bench for seg7_bcd_scanner
module tb_seg7_bcd_scanner;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FL = 4 * RD;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = 4'b0000;
  logic [3:0]  blink_en = 4'b0000;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;

  logic [15:0] s_dig = 16'h0000;
  logic        s_lz = 1'b0;
  logic [3:0]  s_dp = 4'b0000;
  logic [3:0]  s_bl = 4'b0000;
  logic [6:0]  glyph [16];

  always #5 clk = ~clk;

  seg7_bcd_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .clr      (clr),
    .digits   (digits),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .blink_en (blink_en),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Slot s = k-2 counts displayed digit periods since release; frames are 4 slots long
  function automatic logic [11:0] expect_out(input logic in_reset);
    int s, idx, f, ph, v;
    logic blank;
    if (in_reset || k < 2) return {4'b1111, 7'b1111111, 1'b1};
    s     = k - 2;
    idx   = (s / RD) % 4;
    f     = s / FL;
    ph    = (f / BF) % 2;
    v     = (s_dig >> (4 * idx)) & 16'hF;
    blank = (s_lz && idx > 0 && (s_dig >> (4 * idx)) == 0) || (ph == 1 && s_bl[idx]);
    if (blank) return {4'b1111, 7'b1111111, 1'b1};
    return {~(4'b0001 << idx), glyph[v], ~s_dp[idx]};
  endfunction

  task automatic tick(input string tag);
    logic [11:0] exp;
    @(posedge clk);
    #1;
    if (clr) k = 0;
    else k++;
    exp = expect_out(clr);
    check_eq(tag, {an, seg, dp}, exp);
    if (!clr && k >= 1 && (k - 1) % FL == 0) begin
      s_dig = digits;
      s_lz  = blank_lz;
      s_dp  = dp_mask;
      s_bl  = blink_en;
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic run_to_snap(input string tag);
    for (int i = 0; i < FL + 2; i++) begin
      tick(tag);
      if (k >= 1 && (k - 1) % FL == 0) return;
    end
    check_eq({tag, "_snap_timeout"}, 32'(k), 32'(k + 1));
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100; glyph[3] = 7'b0110000;
    glyph[4] = 7'b0011001; glyph[5] = 7'b0010010; glyph[6] = 7'b0000010; glyph[7] = 7'b1111000;
    glyph[8] = 7'b0000000; glyph[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) glyph[i] = 7'b0111111;

    digits = 16'h1234;
    run(3, "reset");
    check_eq("reset_an", 32'(an), 32'h0000000F);
    check_eq("reset_seg", 32'(seg), 32'h0000007F);
    clr = 1'b0;
    tick("first");
    check_eq("first_an", 32'(an), 32'b1111);
    tick("frame0");
    check_eq("frame0_an0", 32'(an), 32'b1110);
    check_eq("frame0_seg0", 32'(seg), 32'b0011001);
    run(3, "frame0");
    tick("frame0");
    check_eq("frame0_an1", 32'(an), 32'b1101);
    check_eq("frame0_seg1", 32'(seg), 32'b0110000);
    run(3, "frame0");
    tick("frame0");
    check_eq("frame0_an2", 32'(an), 32'b1011);
    run(3, "frame0");
    tick("frame0");
    check_eq("frame0_an3", 32'(an), 32'b0111);
    check_eq("frame0_seg3", 32'(seg), 32'b1111001);

    digits = 16'h0050; blank_lz = 1'b1;
    run_to_snap("lz50");
    run(2 * FL, "lz50");
    digits = 16'h0000;
    run_to_snap("lz00");
    run(2 * FL, "lz00");

    blank_lz = 1'b0; digits = 16'h1111;
    run_to_snap("coh");
    run(5, "coh");
    digits = 16'h9999;
    run(2 * FL, "coh");

    blink_en = 4'b0001; digits = 16'h5678;
    run_to_snap("blink");
    run(6 * FL, "blink");
    blink_en = 4'b0000;

    digits = 16'hA000; dp_mask = 4'b1000; blank_lz = 1'b1;
    run_to_snap("dash");
    tick("dash");
    check_eq("dash_seg0", 32'(seg), 32'b1000000);
    run(2 * FL, "dash");

    digits = 16'h4321; dp_mask = 4'b0101; blank_lz = 1'b0;
    run_to_snap("midrst");
    run(9, "midrst");
    clr = 1'b1;
    tick("midrst");
    check_eq("midrst_an", 32'(an), 32'b1111);
    clr = 1'b0;
    digits = 16'h0907;
    run(2 * FL, "midrst");

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits   = rand_digits();
        blank_lz = 1'($urandom_range(0, 1));
        dp_mask  = 4'($urandom_range(0, 15));
        blink_en = 4'($urandom_range(0, 15));
      end
      clr = ($urandom_range(0, 299) == 0);
      tick("rand");
    end
    clr = 1'b0;
    run(FL, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
